uc_sweep_ctrl: RTL and testbench

- Frequency-sweep scheduler for the uberclock RX channel.
- Steps the downconversion phase increment through a programmed list of points (start + k*step).
- At each point it waits a settling time measured in decimated samples (ce_down), then averages 2^AVG magnitude samples and captures the final phase sample.
- Emits one result per point to the CPU over a valid/ready handshake. Its phase_inc_down output replaces the static CSR value feeding rx_channel.

---
 rtl/uc_sweep_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_uc_sweep_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uc_sweep_ctrl.sv
// rtl/uc_sweep_ctrl.sv - frequency-sweep scheduler: steps phase increment, settles, averages magnitude, emits one result per point
module uc_sweep_ctrl #(
    parameter int PW       = 19,
    parameter int MAG_W    = 16,
    parameter int PH_W     = 25,
    parameter int NPTS_W   = 10,
    parameter int SETTLE_W = 16,
    parameter int AVG_MAX  = 4
) (
    input  logic                       sys_clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [PW-1:0]              f_start,
    input  logic [PW-1:0]              f_step,
    input  logic [NPTS_W-1:0]          n_points,
    input  logic [SETTLE_W-1:0]        settle_samples,
    input  logic [2:0]                 avg_log2,
    input  logic                       ce_down,
    input  logic signed [MAG_W-1:0]    magnitude,
    input  logic signed [PH_W-1:0]     phase,
    output logic [PW-1:0]              phase_inc_down,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [NPTS_W-1:0]          res_index,
    output logic signed [MAG_W-1:0]    res_mag,
    output logic signed [PH_W-1:0]     res_phase,
    output logic                       busy,
    output logic                       done
);
    localparam int ACC_W = MAG_W + AVG_MAX;
    localparam int CNT_W = AVG_MAX + 1;

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_ACQ, S_EMIT, S_STEP} state_t;

    state_t                    state_q, state_d;
    logic [PW-1:0]             pinc_q, pinc_d, step_q, step_d;
    logic [NPTS_W-1:0]         npts_q, npts_d, index_q, index_d, res_index_q, res_index_d;
    logic [SETTLE_W-1:0]       settle_q, settle_d, scnt_q, scnt_d;
    logic [2:0]                avg_q, avg_d;
    logic [CNT_W-1:0]          acnt_q, acnt_d, acq_target;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [MAG_W-1:0]   res_mag_q, res_mag_d;
    logic signed [PH_W-1:0]    res_phase_q, res_phase_d;
    logic                      res_valid_q, res_valid_d, done_q, done_d;
    logic                      go_acq;

    assign acq_target = CNT_W'(1) << avg_q;

    always_comb begin
        state_d     = state_q;
        pinc_d      = pinc_q;
        step_d      = step_q;
        npts_d      = npts_q;
        index_d     = index_q;
        res_index_d = res_index_q;
        settle_d    = settle_q;
        scnt_d      = scnt_q;
        avg_d       = avg_q;
        acnt_d      = acnt_q;
        acc_d       = acc_q;
        res_mag_d   = res_mag_q;
        res_phase_d = res_phase_q;
        res_valid_d = res_valid_q;
        done_d      = 1'b0;
        go_acq      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    step_d   = f_step;
                    npts_d   = n_points;
                    settle_d = settle_samples;
                    avg_d    = (avg_log2 > 3'(AVG_MAX)) ? 3'(AVG_MAX) : avg_log2;
                    if (n_points == '0) begin
                        done_d = 1'b1;
                    end else begin
                        pinc_d  = f_start;
                        index_d = '0;
                        scnt_d  = '0;
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (settle_q == '0) begin
                    go_acq = 1'b1;
                end else if (ce_down) begin
                    if (scnt_q + SETTLE_W'(1) == settle_q) go_acq = 1'b1;
                    else scnt_d = scnt_q + SETTLE_W'(1);
                end
                if (go_acq) begin
                    state_d = S_ACQ;
                    acc_d   = '0;
                    acnt_d  = '0;
                end
            end
            S_ACQ: begin
                // Full count is checked first so a strobe in the finishing cycle is dropped.
                if (acnt_q == acq_target) begin
                    res_mag_d   = MAG_W'(acc_q >>> avg_q);
                    res_index_d = index_q;
                    res_valid_d = 1'b1;
                    state_d     = S_EMIT;
                end else if (ce_down) begin
                    acc_d       = acc_q + ACC_W'(magnitude);
                    res_phase_d = phase;
                    acnt_d      = acnt_q + CNT_W'(1);
                end
            end
            S_EMIT: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    if (index_q == npts_q - NPTS_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_STEP;
                    end
                end
            end
            S_STEP: begin
                pinc_d  = pinc_q + step_q;
                index_d = index_q + NPTS_W'(1);
                scnt_d  = '0;
                state_d = S_SETTLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            res_valid_d = 1'b0;
            done_d      = 1'b0;
            pinc_d      = pinc_q;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pinc_q      <= '0;
            step_q      <= '0;
            npts_q      <= '0;
            index_q     <= '0;
            res_index_q <= '0;
            settle_q    <= '0;
            scnt_q      <= '0;
            avg_q       <= '0;
            acnt_q      <= '0;
            acc_q       <= '0;
            res_mag_q   <= '0;
            res_phase_q <= '0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pinc_q      <= pinc_d;
            step_q      <= step_d;
            npts_q      <= npts_d;
            index_q     <= index_d;
            res_index_q <= res_index_d;
            settle_q    <= settle_d;
            scnt_q      <= scnt_d;
            avg_q       <= avg_d;
            acnt_q      <= acnt_d;
            acc_q       <= acc_d;
            res_mag_q   <= res_mag_d;
            res_phase_q <= res_phase_d;
            res_valid_q <= res_valid_d;
            done_q      <= done_d;
        end
    end

    assign phase_inc_down = pinc_q;
    assign res_valid      = res_valid_q;
    assign res_index      = res_index_q;
    assign res_mag        = res_mag_q;
    assign res_phase      = res_phase_q;
    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
endmodule

// File: tb/tb_uc_sweep_ctrl.sv
// tb/tb_uc_sweep_ctrl.sv - self-checking bench for uc_sweep_ctrl against a timeline reference model
module tb_uc_sweep_ctrl;
    localparam int PW = 19, MAG_W = 16, PH_W = 25, NPTS_W = 10, SETTLE_W = 16, AVG_MAX = 4;
    localparam int MAXC = 1024;

    logic sys_clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic [PW-1:0] f_start = '0, f_step = '0;
    logic [NPTS_W-1:0] n_points = '0;
    logic [SETTLE_W-1:0] settle_samples = '0;
    logic [2:0] avg_log2 = '0;
    logic ce_down = 1'b0, res_ready = 1'b0;
    logic signed [MAG_W-1:0] magnitude = '0;
    logic signed [PH_W-1:0] phase = '0;
    logic [PW-1:0] phase_inc_down;
    logic res_valid, busy, done;
    logic [NPTS_W-1:0] res_index;
    logic signed [MAG_W-1:0] res_mag;
    logic signed [PH_W-1:0] res_phase;

    uc_sweep_ctrl #(.PW(PW), .MAG_W(MAG_W), .PH_W(PH_W), .NPTS_W(NPTS_W),
                    .SETTLE_W(SETTLE_W), .AVG_MAX(AVG_MAX)) dut (
        .sys_clk(sys_clk), .rst(rst), .start(start), .abort(abort),
        .f_start(f_start), .f_step(f_step), .n_points(n_points),
        .settle_samples(settle_samples), .avg_log2(avg_log2),
        .ce_down(ce_down), .magnitude(magnitude), .phase(phase),
        .phase_inc_down(phase_inc_down), .res_valid(res_valid), .res_ready(res_ready),
        .res_index(res_index), .res_mag(res_mag), .res_phase(res_phase),
        .busy(busy), .done(done)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0, n_bad = 0;

    // Per-cycle stimulus; cycle 0 is the cycle in which start is driven.
    bit ce_a[MAXC], rdy_a[MAXC], stx_a[MAXC];
    logic signed [MAG_W-1:0] mag_a[MAXC];
    logic signed [PH_W-1:0]  ph_a[MAXC];
    // Expected outputs observed during each cycle.
    bit e_busy[MAXC], e_done[MAXC], e_valid[MAXC];
    logic [PW-1:0] e_pinc[MAXC];
    logic [NPTS_W-1:0] e_idx[MAXC];
    logic signed [MAG_W-1:0] e_mag[MAXC];
    logic signed [PH_W-1:0]  e_ph[MAXC];

    logic [PW-1:0] c_fs, c_fstep, pinc_prev;
    int c_n, c_settle, c_avg, abort_cyc, last_busy;
    int a_cyc[8];
    bit model_ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_rand(input int ce_den, input int rdy_den);
        for (int c = 0; c < MAXC; c++) begin
            ce_a[c]  = ($urandom_range(0, ce_den - 1) == 0);
            rdy_a[c] = ($urandom_range(0, rdy_den - 1) == 0);
            mag_a[c] = MAG_W'($urandom);
            ph_a[c]  = PH_W'($urandom);
            stx_a[c] = 1'b0;
        end
    endtask

    // Timeline model: point k settles from cycle e, acquires the next 2^avg strobes,
    // presents its result two cycles after the last strobe, next point enters 2 cycles after the handshake.
    task automatic build_model();
        int e, c, a, cnt, sum, av, n, v, h;
        logic [PW-1:0] pk;
        logic signed [PH_W-1:0] lph;
        model_ovf = 1'b0;
        h = 0;
        for (int t = 0; t < MAXC; t++) begin
            e_busy[t] = 0; e_done[t] = 0; e_valid[t] = 0;
            e_pinc[t] = pinc_prev; e_idx[t] = '0; e_mag[t] = '0; e_ph[t] = '0;
        end
        last_busy = 0;
        if (c_n == 0) begin
            e_done[1] = 1;
        end else begin
            av = (c_avg > AVG_MAX) ? AVG_MAX : c_avg;
            n  = 1 << av;
            e  = 1;
            for (int k = 0; k < c_n; k++) begin
                pk = PW'(c_fs + k * c_fstep);
                for (int t = e; t < MAXC; t++) e_pinc[t] = pk;
                c = e; cnt = 0;
                while (cnt < c_settle && c < MAXC - 8) begin
                    if (ce_a[c]) cnt++;
                    c++;
                end
                a = (c_settle == 0) ? e + 1 : c;
                a_cyc[k] = a;
                c = a; cnt = 0; sum = 0; lph = '0;
                while (cnt < n && c < MAXC - 8) begin
                    if (ce_a[c]) begin
                        sum += int'(mag_a[c]);
                        lph = ph_a[c];
                        cnt++;
                    end
                    c++;
                end
                v = c + 1; h = v;
                while (!rdy_a[h] && h < MAXC - 8) h++;
                if (h >= MAXC - 8) model_ovf = 1'b1;
                for (int t = v; t <= h; t++) begin
                    e_valid[t] = 1;
                    e_idx[t]   = NPTS_W'(k);
                    e_mag[t]   = MAG_W'(sum >>> av);
                    e_ph[t]    = lph;
                end
                e = h + 2;
            end
            for (int t = 1; t <= h; t++) e_busy[t] = 1;
            e_done[h + 1] = 1;
            last_busy = h;
            if (abort_cyc > 0 && abort_cyc <= h) begin
                for (int t = abort_cyc + 1; t < MAXC; t++) begin
                    e_busy[t] = 0; e_done[t] = 0; e_valid[t] = 0;
                    e_pinc[t] = e_pinc[abort_cyc];
                end
                last_busy = abort_cyc;
            end
        end
    endtask

    task automatic add_stray_starts();
        for (int c = 1; c <= last_busy; c++) stx_a[c] = ($urandom_range(0, 15) == 0);
    endtask

    task automatic run_sweep(input string name);
        int run_end;
        run_end = last_busy + 4;
        chk({name, ":model_budget"}, 64'(model_ovf), 64'd0);
        for (int c = 0; c <= run_end; c++) begin
            @(negedge sys_clk);
            chk({name, ":busy"}, 64'(busy), 64'(e_busy[c]));
            chk({name, ":done"}, 64'(done), 64'(e_done[c]));
            chk({name, ":res_valid"}, 64'(res_valid), 64'(e_valid[c]));
            chk({name, ":phase_inc"}, 64'(phase_inc_down), 64'(e_pinc[c]));
            if (e_valid[c]) begin
                chk({name, ":res_index"}, 64'(res_index), 64'(e_idx[c]));
                chk({name, ":res_mag"}, 64'(res_mag), 64'(e_mag[c]));
                chk({name, ":res_phase"}, 64'(res_phase), 64'(e_ph[c]));
            end
            start     = (c == 0) || stx_a[c];
            abort     = (c == abort_cyc);
            ce_down   = ce_a[c];
            magnitude = mag_a[c];
            phase     = ph_a[c];
            res_ready = rdy_a[c];
            if (c == 0) begin
                f_start = c_fs; f_step = c_fstep; n_points = NPTS_W'(c_n);
                settle_samples = SETTLE_W'(c_settle); avg_log2 = 3'(c_avg);
            end else begin
                f_start = PW'($urandom); f_step = PW'($urandom);
                n_points = NPTS_W'($urandom_range(0, 5));
                settle_samples = SETTLE_W'($urandom_range(0, 9)); avg_log2 = 3'($urandom);
            end
        end
        @(negedge sys_clk);
        start = 0; abort = 0; ce_down = 0; res_ready = 0;
        pinc_prev = e_pinc[run_end];
    endtask

    task automatic fill_basic();
        int p;
        p = 0;
        for (int c = 0; c < MAXC; c++) begin
            ce_a[c]  = (c % 4 == 0);
            mag_a[c] = (p % 2 == 0) ? 16'sd100 : 16'sd200;
            if (ce_a[c]) p++;
            ph_a[c]  = PH_W'($urandom);
            rdy_a[c] = 1;
            stx_a[c] = 0;
        end
        c_fs = 19'd1000; c_fstep = 19'd500; c_n = 3; c_settle = 2; c_avg = 1;
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        chk("reset:busy", 64'(busy), 64'd0);
        chk("reset:done", 64'(done), 64'd0);
        chk("reset:res_valid", 64'(res_valid), 64'd0);
        chk("reset:phase_inc", 64'(phase_inc_down), 64'd0);
        chk("reset:res_mag", 64'(res_mag), 64'd0);
        chk("reset:res_index", 64'(res_index), 64'd0);
        rst = 1'b0;
        pinc_prev = '0;
        abort_cyc = -1;

        fill_basic(); build_model(); run_sweep("basic");

        fill_basic();
        for (int c = 0; c < 70; c++) rdy_a[c] = 0;
        build_model(); run_sweep("ready_hold");

        fill_rand(3, 2);
        c_fs = 19'h7FF00; c_fstep = 19'h00200; c_n = 2; c_settle = 1; c_avg = 0;
        build_model(); run_sweep("wrap");

        fill_basic(); build_model();
        abort_cyc = a_cyc[1]; build_model(); run_sweep("abort_acq");
        abort_cyc = -1;

        fill_rand(2, 1);
        c_fs = 19'd777; c_fstep = 19'd1; c_n = 0; c_settle = 3; c_avg = 2;
        build_model(); run_sweep("zero_points");

        fill_rand(2, 1);
        for (int c = 0; c < MAXC; c++) mag_a[c] = -16'sd8;
        c_fs = 19'd5; c_fstep = 19'd5; c_n = 1; c_settle = 0; c_avg = 7;
        build_model(); run_sweep("avg_clamp");

        fill_basic(); build_model(); add_stray_starts(); run_sweep("busy_start");

        for (int r = 0; r < 10; r++) begin
            fill_rand($urandom_range(1, 4), $urandom_range(1, 3));
            c_fs = PW'($urandom); c_fstep = PW'($urandom);
            c_n = $urandom_range(1, 4); c_settle = $urandom_range(0, 5); c_avg = $urandom_range(0, 7);
            abort_cyc = -1;
            build_model();
            if ($urandom_range(0, 2) == 0) begin
                abort_cyc = $urandom_range(2, last_busy);
                build_model();
            end
            add_stray_starts();
            run_sweep("random");
        end
        abort_cyc = -1;

        fill_basic();
        @(negedge sys_clk);
        start = 1; f_start = c_fs; f_step = c_fstep; n_points = 3; settle_samples = 2; avg_log2 = 1;
        @(negedge sys_clk);
        start = 0;
        repeat (6) @(negedge sys_clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset:busy", 64'(busy), 64'd0);
        chk("midreset:phase_inc", 64'(phase_inc_down), 64'd0);
        chk("midreset:res_valid", 64'(res_valid), 64'd0);
        chk("midreset:done", 64'(done), 64'd0);
        @(negedge sys_clk);
        rst = 1'b0;
        pinc_prev = '0;

        fill_rand(3, 2);
        c_fs = 19'd12345; c_fstep = 19'd678; c_n = 2; c_settle = 3; c_avg = 3;
        build_model(); run_sweep("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
